// File: rtl/md_hilo_unit.sv
// Multiply/divide unit with architectural HI/LO registers for the EX stage.
// MULT/DIV results are staged at accept and committed to HI/LO when the busy count expires.
module md_hilo_unit #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic        stall,
  output logic        hilo_sel,
  output logic [31:0] hilo_out,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  logic [CW-1:0] cnt;
  logic [31:0]   staged_hi, staged_lo;
  logic          valid_op;

  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag;
  logic [31:0] q_s, r_s, rt_safe, q_u, r_u;

  assign valid_op = (op >= OP_MULT) && (op <= OP_MFLO);
  assign stall    = busy && valid_op;
  assign hilo_sel = !busy && ((op == OP_MFHI) || (op == OP_MFLO));
  assign hilo_out = !hilo_sel ? 32'h0 : ((op == OP_MFHI) ? hi : lo);

  // Products are taken modulo 2^64 from sign- or zero-extended operands.
  assign prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
  assign prod_u = {32'h0, rs_val} * {32'h0, rt_val};

  // Signed divide on magnitudes, then re-sign; 80000000/FFFFFFFF falls out as 80000000 rem 0.
  assign a_mag   = rs_val[31] ? (32'h0 - rs_val) : rs_val;
  assign b_mag   = rt_val[31] ? (32'h0 - rt_val) : rt_val;
  assign b_safe  = (rt_val == 32'h0) ? 32'h1 : b_mag;
  assign q_mag   = a_mag / b_safe;
  assign r_mag   = a_mag % b_safe;
  assign q_s     = (rs_val[31] ^ rt_val[31]) ? (32'h0 - q_mag) : q_mag;
  assign r_s     = rs_val[31] ? (32'h0 - r_mag) : r_mag;
  assign rt_safe = (rt_val == 32'h0) ? 32'h1 : rt_val;
  assign q_u     = rs_val / rt_safe;
  assign r_u     = rs_val % rt_safe;

  always_ff @(posedge clk) begin
    if (reset) begin
      busy      <= 1'b0;
      cnt       <= '0;
      staged_hi <= 32'h0;
      staged_lo <= 32'h0;
      hi        <= 32'h0;
      lo        <= 32'h0;
    end else if (busy) begin
      if (cnt == '0) begin
        busy <= 1'b0;
        hi   <= staged_hi;
        lo   <= staged_lo;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end else begin
      case (op)
        OP_MULT: begin
          {staged_hi, staged_lo} <= prod_s;
          busy <= 1'b1;
          cnt  <= CW'(MUL_CYCLES - 1);
        end
        OP_MULTU: begin
          {staged_hi, staged_lo} <= prod_u;
          busy <= 1'b1;
          cnt  <= CW'(MUL_CYCLES - 1);
        end
        OP_DIV: begin
          staged_hi <= (rt_val == 32'h0) ? rs_val : r_s;
          staged_lo <= (rt_val == 32'h0) ? 32'hFFFF_FFFF : q_s;
          busy <= 1'b1;
          cnt  <= CW'(DIV_CYCLES - 1);
        end
        OP_DIVU: begin
          staged_hi <= (rt_val == 32'h0) ? rs_val : r_u;
          staged_lo <= (rt_val == 32'h0) ? 32'hFFFF_FFFF : q_u;
          busy <= 1'b1;
          cnt  <= CW'(DIV_CYCLES - 1);
        end
        OP_MTHI: hi <= rs_val;
        OP_MTLO: lo <= rs_val;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_md_hilo_unit.sv
// Randomized bench for md_hilo_unit: an arithmetic reference model feeds per-cycle and
// MFHI/MFLO expectation queues that an independent negedge monitor drains.
module tb_md_hilo_unit;

  localparam int MUL_CYCLES = 5;
  localparam int DIV_CYCLES = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  op;
  logic [31:0] rs_val, rt_val;
  logic        busy, stall, hilo_sel;
  logic [31:0] hilo_out, hi, lo;

  md_hilo_unit #(.MUL_CYCLES(MUL_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clk(clk), .reset(reset), .op(op), .rs_val(rs_val), .rt_val(rt_val),
    .busy(busy), .stall(stall), .hilo_sel(hilo_sel), .hilo_out(hilo_out),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        stall;
    logic        busy;
    logic        sel;
    logic [31:0] hi;
    logic [31:0] lo;
  } rec_t;

  rec_t        cyc_q[$];
  logic [31:0] exp_q[$];

  int errors = 0;
  int checks = 0;

  // Reference model: architectural HI/LO, pending result and remaining busy cycles.
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  int          m_busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_result(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    longint sp;
    longint unsigned up;
    sa = a;
    sb = b;
    case (o)
      4'd1: begin sp = longint'(sa) * longint'(sb); {p_hi, p_lo} = sp; end
      4'd2: begin up = longint'({32'h0, a}) * longint'({32'h0, b}); {p_hi, p_lo} = up; end
      4'd3: begin
        if (b == 0) begin p_lo = 32'hFFFF_FFFF; p_hi = a; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin p_lo = a; p_hi = 0; end
        else begin p_lo = sa / sb; p_hi = sa % sb; end
      end
      default: begin
        if (b == 0) begin p_lo = 32'hFFFF_FFFF; p_hi = a; end
        else begin p_lo = a / b; p_hi = a % b; end
      end
    endcase
  endtask

  // One cycle: present inputs, record what the DUT must show this cycle, then advance the model.
  task automatic drive(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic rst, output logic acc);
    logic v, st, sel;
    rec_t r;
    @(posedge clk);
    #1;
    op = o; rs_val = a; rt_val = b; reset = rst;
    v   = (o >= 1) && (o <= 8);
    st  = (m_busy > 0) && v;
    sel = (m_busy == 0) && (o == 4'd7 || o == 4'd8);
    r.stall = st; r.busy = (m_busy > 0); r.sel = sel; r.hi = m_hi; r.lo = m_lo;
    cyc_q.push_back(r);
    if (sel) exp_q.push_back((o == 4'd7) ? m_hi : m_lo);
    acc = v && !st;
    if (rst) begin
      m_hi = 0; m_lo = 0; m_busy = 0;
    end else if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin m_hi = p_hi; m_lo = p_lo; end
    end else if (v) begin
      case (o)
        4'd1, 4'd2: begin model_result(o, a, b); m_busy = MUL_CYCLES; end
        4'd3, 4'd4: begin model_result(o, a, b); m_busy = DIV_CYCLES; end
        4'd5: m_hi = a;
        4'd6: m_lo = a;
        default: ;
      endcase
    end
  endtask

  // Pipeline behaviour: re-present the op until it is no longer stalled.
  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int tries);
    logic acc;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 40) begin
      drive(o, a, b, 1'b0, acc);
      tries++;
    end
    if (!acc) begin
      errors++;
      $display("FAIL issue_timeout: op %0d not accepted after %0d cycles", o, tries);
    end
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) drive(4'd0, $urandom, $urandom, 1'b0, acc);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: compares each recorded cycle and every MFHI/MFLO result the DUT presents.
  always @(negedge clk) begin
    rec_t r;
    if (cyc_q.size() > 0) begin
      r = cyc_q.pop_front();
      chk("stall", {31'h0, stall}, {31'h0, r.stall});
      chk("busy", {31'h0, busy}, {31'h0, r.busy});
      chk("hilo_sel", {31'h0, hilo_sel}, {31'h0, r.sel});
      chk("hi", hi, r.hi);
      chk("lo", lo, r.lo);
      if (hilo_sel) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL hilo_unexpected: hilo_sel=1 out=%08h with no expected read", hilo_out);
        end else begin
          chk("hilo_out", hilo_out, exp_q.pop_front());
        end
      end else begin
        chk("hilo_out_idle", hilo_out, 32'h0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int tries;
    logic acc;
    logic [3:0] o;
    reset = 1'b1; op = 4'd0; rs_val = 0; rt_val = 0;
    m_hi = 0; m_lo = 0; p_hi = 0; p_lo = 0; m_busy = 0;
    repeat (3) @(posedge clk);
    idle(1);
    #1;
    chk("reset_busy", {31'h0, busy}, 32'h0);
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);

    issue(4'd2, 32'hFFFF_FFFF, 32'h2, tries);
    idle(MUL_CYCLES + 1);
    #1;
    chk("t1_hi", hi, 32'h0000_0001);
    chk("t1_lo", lo, 32'hFFFF_FFFE);

    issue(4'd1, 32'hFFFF_FFFD, 32'h5, tries);
    idle(MUL_CYCLES);
    issue(4'd8, 0, 0, tries);
    #1;
    chk("t2_tries", 32'(tries), 32'd1);
    chk("t2_sel", {31'h0, hilo_sel}, 32'h1);
    chk("t2_out", hilo_out, 32'hFFFF_FFF1);
    chk("t2_hi", hi, 32'hFFFF_FFFF);

    issue(4'd3, 32'hFFFF_FFF9, 32'h2, tries);
    idle(DIV_CYCLES + 1);
    #1;
    chk("t3_div_lo", lo, 32'hFFFF_FFFD);
    chk("t3_div_hi", hi, 32'hFFFF_FFFF);
    issue(4'd4, 32'h7, 32'h0, tries);
    idle(DIV_CYCLES + 1);
    #1;
    chk("t3_divu0_lo", lo, 32'hFFFF_FFFF);
    chk("t3_divu0_hi", hi, 32'h7);

    issue(4'd1, 32'h0001_0000, 32'h0003_0000, tries);
    issue(4'd7, 0, 0, tries);
    #1;
    chk("t4_tries", 32'(tries), 32'(MUL_CYCLES + 1));
    chk("t4_out", hilo_out, 32'h0000_0003);

    issue(4'd5, 32'h1234_5678, 0, tries);
    issue(4'd7, 0, 0, tries);
    #1;
    chk("t5_tries", 32'(tries), 32'd1);
    chk("t5_out", hilo_out, 32'h1234_5678);
    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, tries);
    idle(DIV_CYCLES + 1);
    #1;
    chk("t5_ovf_lo", lo, 32'h8000_0000);
    chk("t5_ovf_hi", hi, 32'h0);

    issue(4'd6, 32'hCAFE_F00D, 0, tries);
    issue(4'd3, 32'd100, 32'd7, tries);
    idle(3);
    drive(4'd0, 0, 0, 1'b1, acc);
    idle(1);
    #1;
    chk("t6_busy", {31'h0, busy}, 32'h0);
    chk("t6_hi", hi, 32'h0);
    chk("t6_lo", lo, 32'h0);
    idle(DIV_CYCLES + 2);
    #1;
    chk("t6_late_hi", hi, 32'h0);
    chk("t6_late_lo", lo, 32'h0);

    for (int n = 0; n < 300; n++) begin
      o = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 49) == 0) drive(o, rand_operand(), rand_operand(), 1'b1, acc);
      else if (o >= 1 && o <= 8) issue(o, rand_operand(), rand_operand(), tries);
      else drive(o, rand_operand(), rand_operand(), 1'b0, acc);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 12));
    end

    idle(DIV_CYCLES + 2);
    @(negedge clk);
    #1;
    chk("cyc_q_drained", 32'(cyc_q.size()), 32'h0);
    chk("exp_q_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
